// File: rtl/fetch_sequencer.sv
// Instruction fetch address sequencer: run handshake, relative branches,
// absolute calls with a hardware return stack, stall/halt and a sticky stack-error flag.
module fetch_sequencer #(
    parameter int PC_W    = 10,
    parameter int OFF_W   = 8,
    parameter int STACK_D = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchUp,
    input  logic             BranchDown,
    input  logic             Call,
    input  logic             Return,
    input  logic [OFF_W-1:0] PCTarget,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Ack,
    output logic             Running,
    output logic             StackErr
);

    localparam int IDX_W = $clog2(STACK_D);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_D);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              ack_q, ack_d;
    logic              running_q, running_d;
    logic              err_q, err_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              push_en;
    logic [PC_W-1:0]   stack_q [STACK_D];

    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   tgt_ext;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              stack_empty;
    logic              stack_full;

    // sp_q counts live entries, so the top entry sits one below it
    assign pc_inc      = pc_q + PC_W'(1);
    assign tgt_ext     = PC_W'(PCTarget);
    assign push_idx    = IDX_W'(sp_q);
    assign top_idx     = IDX_W'(sp_q - SP_W'(1));
    assign stack_empty = (sp_q == SP_W'(0));
    assign stack_full  = (sp_q == SP_FULL);

    // State and control registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ack_q     <= 1'b0;
            running_q <= 1'b0;
            err_q     <= 1'b0;
            sp_q      <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ack_q     <= ack_d;
            running_q <= running_d;
            err_q     <= err_d;
            sp_q      <= sp_d;
        end
    end

    // Return stack storage; contents are not reset
    always_ff @(posedge Clk) begin
        if (push_en && !Reset) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_ARMED;
                else       state_d = S_IDLE;
            end
            S_ARMED: begin
                if (Start) state_d = S_ARMED;
                else       state_d = S_RUN;
            end
            S_RUN: begin
                if (Start)       state_d = S_ARMED;
                else if (Stall)  state_d = S_RUN;
                else if (Halt)   state_d = S_DONE;
                else if (Return) state_d = stack_empty ? S_DONE : S_RUN;
                else if (Call)   state_d = stack_full ? S_DONE : S_RUN;
                else             state_d = S_RUN;
            end
            S_DONE: begin
                if (Start) state_d = S_ARMED;
                else       state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; strobes act only in RUN, in priority order
    always_comb begin
        pc_d    = pc_q;
        err_d   = err_q;
        sp_d    = sp_q;
        push_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) pc_d = '0;
                else       pc_d = pc_q;
            end
            S_ARMED: begin
                pc_d = '0;
            end
            S_RUN: begin
                if (Start) begin
                    pc_d  = '0;
                    sp_d  = '0;
                    err_d = 1'b0;
                end else if (Stall || Halt) begin
                    pc_d = pc_q;
                end else if (Return) begin
                    if (stack_empty) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d = stack_q[top_idx];
                        sp_d = sp_q - SP_W'(1);
                    end
                end else if (Call) begin
                    if (stack_full) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        pc_d    = tgt_ext;
                        sp_d    = sp_q + SP_W'(1);
                    end
                end else if (BranchUp) begin
                    pc_d = pc_q + tgt_ext;
                end else if (BranchDown) begin
                    pc_d = pc_q - tgt_ext;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_DONE: begin
                if (Start) begin
                    pc_d  = '0;
                    sp_d  = '0;
                    err_d = 1'b0;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = '0;
                sp_d = '0;
            end
        endcase
        ack_d     = (state_d == S_DONE);
        running_d = (state_d == S_RUN);
    end

    assign ProgCtr  = pc_q;
    assign Ack      = ack_q;
    assign Running  = running_q;
    assign StackErr = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed steps push expected outputs,
// an independent monitor pops and compares one entry per clock.
module tb_fetch_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0, Stall = 1'b0, Halt = 1'b0;
    logic       BranchUp = 1'b0, BranchDown = 1'b0, Call = 1'b0, Return = 1'b0;
    logic [7:0] PCTarget = 8'd0;
    logic [9:0] ProgCtr;
    logic       Ack, Running, StackErr;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [9:0] pc;
        logic       ack;
        logic       run;
        logic       err;
        string      nm;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] ST   = 7'b1000000;
    localparam logic [6:0] SL   = 7'b0100000;
    localparam logic [6:0] HT   = 7'b0010000;
    localparam logic [6:0] RT   = 7'b0001000;
    localparam logic [6:0] CL   = 7'b0000100;
    localparam logic [6:0] UP   = 7'b0000010;
    localparam logic [6:0] DN   = 7'b0000001;

    fetch_sequencer #(.PC_W(10), .OFF_W(8), .STACK_D(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
        .BranchUp(BranchUp), .BranchDown(BranchDown), .Call(Call), .Return(Return),
        .PCTarget(PCTarget), .ProgCtr(ProgCtr), .Ack(Ack), .Running(Running),
        .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    task automatic step(input logic rst, input logic [6:0] s, input logic [7:0] tgt,
                        input logic [9:0] epc, input logic eack, input logic erun,
                        input logic eerr, input string nm);
        exp_t e;
        @(negedge Clk);
        Reset = rst;
        {Start, Stall, Halt, Return, Call, BranchUp, BranchDown} = s;
        PCTarget = tgt;
        e.pc = epc; e.ack = eack; e.run = erun; e.err = eerr; e.nm = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs settle 1 time unit after the edge that consumed the vector
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compared++;
                if (ProgCtr !== e.pc || Ack !== e.ack || Running !== e.run || StackErr !== e.err) begin
                    mismatched++;
                    $display("FAIL %s: got pc=%0d ack=%b run=%b err=%b, expected pc=%0d ack=%b run=%b err=%b",
                             e.nm, ProgCtr, Ack, Running, StackErr, e.pc, e.ack, e.run, e.err);
                end
            end
        end
    end

    initial begin
        // reset
        step(1'b1, NONE, 8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "reset0");
        step(1'b1, NONE, 8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "reset1");
        // 1: start handshake, first fetches
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "armed0");
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "armed1");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "run_pc0");
        step(1'b0, NONE, 8'd0,   10'd1,    1'b0, 1'b1, 1'b0, "run_pc1");
        step(1'b0, NONE, 8'd0,   10'd2,    1'b0, 1'b1, 1'b0, "run_pc2");
        step(1'b0, NONE, 8'd0,   10'd3,    1'b0, 1'b1, 1'b0, "run_pc3");
        // 2: branches and wrap
        step(1'b0, UP,   8'd17,  10'd20,   1'b0, 1'b1, 1'b0, "up_to20");
        step(1'b0, UP,   8'd5,   10'd25,   1'b0, 1'b1, 1'b0, "up5");
        step(1'b0, DN,   8'd30,  10'd1019, 1'b0, 1'b1, 1'b0, "down30_wrap");
        step(1'b0, UP,   8'd4,   10'd1023, 1'b0, 1'b1, 1'b0, "up_to1023");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "inc_wrap");
        step(1'b0, UP,   8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "up0_selfloop");
        // 3: nested call/return
        step(1'b0, UP,   8'd7,   10'd7,    1'b0, 1'b1, 1'b0, "up_to7");
        step(1'b0, CL,   8'd100, 10'd100,  1'b0, 1'b1, 1'b0, "call100");
        step(1'b0, CL,   8'd200, 10'd200,  1'b0, 1'b1, 1'b0, "call200");
        step(1'b0, RT,   8'd0,   10'd101,  1'b0, 1'b1, 1'b0, "ret101");
        step(1'b0, RT,   8'd0,   10'd8,    1'b0, 1'b1, 1'b0, "ret8");
        // 4: overflow, strobes ignored in DONE, underflow
        step(1'b0, CL,   8'd10,  10'd10,   1'b0, 1'b1, 1'b0, "call_d1");
        step(1'b0, CL,   8'd20,  10'd20,   1'b0, 1'b1, 1'b0, "call_d2");
        step(1'b0, CL,   8'd30,  10'd30,   1'b0, 1'b1, 1'b0, "call_d3");
        step(1'b0, CL,   8'd40,  10'd40,   1'b0, 1'b1, 1'b0, "call_d4");
        step(1'b0, CL,   8'd50,  10'd40,   1'b1, 1'b0, 1'b1, "call_overflow");
        step(1'b0, UP,   8'd3,   10'd40,   1'b1, 1'b0, 1'b1, "done_ignores");
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "done_restart");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "run_again");
        step(1'b0, RT,   8'd0,   10'd0,    1'b1, 1'b0, 1'b1, "ret_underflow");
        // 5: halt priority and stall over halt
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "t5_armed");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "t5_run");
        step(1'b0, UP,   8'd12,  10'd12,   1'b0, 1'b1, 1'b0, "t5_up12");
        step(1'b0, HT|UP, 8'd5,  10'd12,   1'b1, 1'b0, 1'b0, "halt_over_up");
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "t5b_armed");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "t5b_run");
        step(1'b0, UP,   8'd12,  10'd12,   1'b0, 1'b1, 1'b0, "t5b_up12");
        step(1'b0, SL|HT, 8'd0,  10'd12,   1'b0, 1'b1, 1'b0, "stall_halt0");
        step(1'b0, SL|HT, 8'd0,  10'd12,   1'b0, 1'b1, 1'b0, "stall_halt1");
        step(1'b0, HT,   8'd0,   10'd12,   1'b1, 1'b0, 1'b0, "halt_after_stall");
        // priority among call/return/branch, abort in RUN clears the stack
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "pr_armed");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "pr_run");
        step(1'b0, CL,   8'd50,  10'd50,   1'b0, 1'b1, 1'b0, "pr_call50");
        step(1'b0, CL|UP, 8'd60, 10'd60,   1'b0, 1'b1, 1'b0, "call_over_up");
        step(1'b0, RT|CL, 8'd99, 10'd51,   1'b0, 1'b1, 1'b0, "ret_over_call");
        step(1'b0, ST|HT, 8'd0,  10'd0,    1'b0, 1'b0, 1'b0, "abort_in_run");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "abort_rerun");
        step(1'b0, RT,   8'd0,   10'd0,    1'b1, 1'b0, 1'b1, "abort_cleared_sp");
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "pr_restart");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "t6_run");
        // 6: reset mid-RUN with two stack entries
        step(1'b0, CL,   8'd53,  10'd53,   1'b0, 1'b1, 1'b0, "t6_call53");
        step(1'b0, CL,   8'd55,  10'd55,   1'b0, 1'b1, 1'b0, "t6_call55");
        step(1'b1, NONE, 8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "reset_mid_run");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "idle_after_reset");
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "t6_armed");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "t6_rerun");
        step(1'b0, RT,   8'd0,   10'd0,    1'b1, 1'b0, 1'b1, "stack_empty_after_reset");
        step(1'b0, ST,   8'd0,   10'd0,    1'b0, 1'b0, 1'b0, "start_in_done");
        step(1'b0, NONE, 8'd0,   10'd0,    1'b0, 1'b1, 1'b0, "final_run");

        @(negedge Clk);
        {Start, Stall, Halt, Return, Call, BranchUp, BranchDown} = NONE;
        repeat (3) @(posedge Clk);
        #2;
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
